spi_flash_reader: RTL and testbench
===================================

// Module: spi_flash_reader
// PURPOSE
//  SPI flash read initiator (mode 0, CPOL=0/CPHA=0): turns a read request (mode, 24-bit addr, length)
//  into a cmd/addr/data transaction with cmd 03h/0Bh/3Bh/6Bh and returns bytes on a valid/ready stream.
//  Sits between the boot/XIP fetch logic and the SPI pads; the flash model in the sim top is its peer.
// PARAMETERS
//  CLK_DIV   2    clk cycles per SCK half-period; legal range >=1.
//  LEN_W     8    width of req_len; a burst is req_len+1 bytes (1..2**LEN_W).
//  DUMMY_CYC 0    SCK cycles between address and data for 0Bh/3Bh/6Bh; 0 matches the in-house model.
// PORTS
//  clk        in   1      system clock; all state on posedge clk.
//  rst_n      in   1      async active-low reset.
//  req_valid  in   1      read request valid.
//  req_ready  out  1      high only in IDLE.
//  req_mode   in   2      spi_pkg::t_rd_mode: 0 READ(03h), 1 FAST(0Bh), 2 DUAL(3Bh), 3 QUAD(6Bh).
//  req_addr   in   24     start byte address.
//  req_len    in   LEN_W  byte count minus one.
//  rsp_valid  out  1      rsp_data holds a received byte.
//  rsp_ready  in   1      consumer accepts byte.
//  rsp_data   out  8      received byte, MSB first on wire.
//  rsp_last   out  1      marks final byte of burst.
//  sck        out  1      SPI clock, idle low.
//  cs_n       out  1      chip select, active low.
//  dq_o       out  4      output data to pads.
//  dq_t       out  4      1 = pad tristated (input).
//  dq_i       in   4      input data from pads.
// BEHAVIOUR
//  - Reset (async, any state): sck=0, cs_n=1, dq_o=0, dq_t=4'hF, req_ready=1, rsp_valid=0, rsp_last=0, FSM=IDLE.
//  - Handshake: request accepted on req_valid&req_ready; fields latched. Response byte transfers on rsp_valid&rsp_ready.
//  - FSM: IDLE -> CSU -> CMD(8 SCK) -> ADDR(24 SCK) -> [DUMMY(DUMMY_CYC SCK), fast modes only] -> DATA -> CSH -> IDLE.
//    CSU: cs_n low, sck low for one half-period; CMD bit7 already on dq_o[0].
//    CSH: after final sample edge, sck returns low; cs_n rises after one more half-period; then IDLE, req_ready=1.
//  - SCK: half-period counter reloads at CLK_DIV-1; sck toggles on terminal count.
//    Rising edge: sample dq_i. Falling edge: shift next out-bit.
//    Edges are registered-out and glitch-free.
//  - CMD/ADDR: single lane, dq_o[0]=MOSI, dq_t=4'b1110, MSB first.
//  - DUMMY, DATA: dq_t=4'hF.
//  - DATA lanes and SCK cycles per byte:
//    READ/FAST: dq_i[1], 8 SCK.
//    DUAL: {dq_i[1],dq_i[0]}, 4 SCK.
//    QUAD: dq_i[3:0], 2 SCK.
//    First nibble/dibit/bit is the MSBs.
//  - Data timing: first data sample on the SCK rise directly after the last addr/dummy SCK cycle (peer drives on the
//    preceding falling edge). Byte completes on its last sample edge; it is loaded into a 1-deep output register
//    (rsp_valid=1 next clk).
//  - Backpressure: if the output register is still full when the next byte's first rising edge is due, sck is held
//    low (stretched). Cycle count and half-period counter are frozen. Resume when the register empties. No byte is
//    ever dropped or sampled twice.
//  - Counting: byte counter = req_len, decremented per byte; rsp_last=1 with the byte at count 0.
//    Address never incremented by master (peer auto-increments); 24-bit wrap is the flash's concern.
//  - req_len=0 yields exactly one byte. Max length 2**LEN_W bytes in one cs_n window.
//  - Reset mid-burst: cs_n rises asynchronously, partial byte discarded, no rsp_valid after reset.
//  - req_valid during a burst is ignored (req_ready=0); inputs must be stable only at the accept cycle.
// STRUCTURE
//  - spi_pkg: t_rd_mode enum; CMD_READ=8'h03, CMD_FAST=8'h0B, CMD_DUAL=8'h3B, CMD_QUAD=8'h6B; t_fsm state enum.
//  - Sub-module spi_sck_gen: divider with en/stall, outputs sck plus rise_stb/fall_stb one-clk strobes.
//  - Top holds FSM, shift registers, bit/byte counters, output register.
// TESTING (bench pairs DUT with the SPI flash model, mem[i]=i[7:0])
//  - READ addr 0x000010 len 3 -> cs_n low for 8+24+32 SCK; bytes 10h,11h,12h,13h; rsp_last on 13h.
//  - QUAD addr 0x000100 len 7 -> MOSI shows 6Bh,00h,01h,00h; data phase 16 SCK; bytes 00h..07h.
//  - DUAL addr 0x0000FE len 1, CLK_DIV=1 -> bytes FEh,FFh; data phase 8 SCK; dq_t=4'hF in data phase.
//  - rsp_ready=0 for 50 clk after first byte (FAST, len 2) -> sck held low, no edges; then bytes 00h,01h,02h intact.
//  - rst_n low mid-ADDR -> cs_n=1, sck=0, dq_t=4'hF same cycle; next request (READ addr 5 len 0) returns 05h only.
//  - Back-to-back requests -> cs_n high >= 1 half-period between bursts; req_ready=0 throughout each burst.

Source files
------------

// File: rtl/spi_pkg.sv
// spi_pkg: shared read-mode/FSM types, command opcodes and per-mode helpers.
// Revision 1.0
`timescale 1ns/1ps
`default_nettype none
package spi_pkg;

  typedef enum logic [1:0] {
    RD_READ = 2'd0,
    RD_FAST = 2'd1,
    RD_DUAL = 2'd2,
    RD_QUAD = 2'd3
  } t_rd_mode;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CSU   = 3'd1,
    S_CMD   = 3'd2,
    S_ADDR  = 3'd3,
    S_DUMMY = 3'd4,
    S_DATA  = 3'd5,
    S_CSH   = 3'd6
  } t_fsm;

  localparam logic [7:0] CMD_READ = 8'h03;
  localparam logic [7:0] CMD_FAST = 8'h0B;
  localparam logic [7:0] CMD_DUAL = 8'h3B;
  localparam logic [7:0] CMD_QUAD = 8'h6B;

  function automatic logic [7:0] rd_cmd(input t_rd_mode m);
    case (m)
      RD_FAST: rd_cmd = CMD_FAST;
      RD_DUAL: rd_cmd = CMD_DUAL;
      RD_QUAD: rd_cmd = CMD_QUAD;
      default: rd_cmd = CMD_READ;
    endcase
  endfunction

  // SCK cycles per received byte, minus one
  function automatic logic [2:0] beats_m1(input t_rd_mode m);
    case (m)
      RD_DUAL: beats_m1 = 3'd3;
      RD_QUAD: beats_m1 = 3'd1;
      default: beats_m1 = 3'd7;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_sck_gen.sv
// spi_sck_gen: SCK divider with enable/stall; rise_stb/fall_stb flag the clk edge at which sck toggles.
// Revision 1.0
`timescale 1ns/1ps
`default_nettype none
module spi_sck_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic stall,
  input  logic park,
  output logic sck,
  output logic rise_stb,
  output logic fall_stb
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt;
  logic             tc;

  assign tc       = en && !stall && (cnt == '0);
  assign rise_stb = tc && !sck;
  assign fall_stb = tc && sck;

  // park keeps sck low while the half-period timer runs; rise_stb then marks its expiry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= RELOAD;
      sck <= 1'b0;
    end else if (!en) begin
      cnt <= RELOAD;
      sck <= 1'b0;
    end else if (!stall) begin
      if (cnt == '0) begin
        cnt <= RELOAD;
        if (sck)       sck <= 1'b0;
        else if (!park) sck <= 1'b1;
      end else begin
        cnt <= cnt - 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/spi_flash_reader.sv
// spi_flash_reader: SPI mode-0 flash read initiator (03h/0Bh/3Bh/6Bh) with a valid/ready byte stream.
// Revision 1.0
`timescale 1ns/1ps
`default_nettype none
module spi_flash_reader
  import spi_pkg::*;
#(
  parameter int CLK_DIV   = 2,
  parameter int LEN_W     = 8,
  parameter int DUMMY_CYC = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_mode,
  input  logic [23:0]      req_addr,
  input  logic [LEN_W-1:0] req_len,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [7:0]       rsp_data,
  output logic             rsp_last,
  output logic             sck,
  output logic             cs_n,
  output logic [3:0]       dq_o,
  output logic [3:0]       dq_t,
  input  logic [3:0]       dq_i
);

  t_fsm             state, state_nxt;
  t_rd_mode         mode;
  logic [31:0]      out_sr;
  logic [7:0]       in_sr, in_nxt;
  logic [7:0]       cyc_cnt;
  logic [2:0]       beat;
  logic [LEN_W-1:0] byte_cnt;
  logic             rise_stb, fall_stb, stall, sck_en, park, byte_done, accept;

  assign req_ready = (state == S_IDLE);
  assign accept    = req_valid && req_ready;
  assign dq_o      = {3'b000, out_sr[31]};
  assign sck_en    = (state != S_IDLE);
  assign park      = (state == S_CSH);
  // hold sck low before a byte's first rise until the output register drains
  assign stall     = (state == S_DATA) && (beat == 3'd0) && rsp_valid && !sck;
  assign byte_done = rise_stb && (state == S_DATA) && (beat == beats_m1(mode));

  spi_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (sck_en),
    .stall    (stall),
    .park     (park),
    .sck      (sck),
    .rise_stb (rise_stb),
    .fall_stb (fall_stb)
  );

  always_comb begin
    in_nxt = {in_sr[6:0], dq_i[1]};
    case (mode)
      RD_DUAL: in_nxt = {in_sr[5:0], dq_i[1:0]};
      RD_QUAD: in_nxt = {in_sr[3:0], dq_i};
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    dq_t      = 4'hF;
    case (state)
      S_IDLE:  if (req_valid) state_nxt = S_CSU;
      S_CSU: begin
        dq_t = 4'b1110;
        if (rise_stb) state_nxt = S_CMD;
      end
      S_CMD: begin
        dq_t = 4'b1110;
        if (fall_stb && cyc_cnt == 8'd8) state_nxt = S_ADDR;
      end
      S_ADDR: begin
        dq_t = 4'b1110;
        if (fall_stb && cyc_cnt == 8'd24)
          state_nxt = (mode != RD_READ && DUMMY_CYC != 0) ? S_DUMMY : S_DATA;
      end
      S_DUMMY: if (fall_stb && cyc_cnt == 8'(DUMMY_CYC)) state_nxt = S_DATA;
      S_DATA:  if (byte_done && byte_cnt == '0) state_nxt = S_CSH;
      S_CSH:   if (rise_stb && cs_n) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode      <= RD_READ;
      out_sr    <= '0;
      in_sr     <= '0;
      cyc_cnt   <= '0;
      beat      <= '0;
      byte_cnt  <= '0;
      cs_n      <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_last  <= 1'b0;
    end else begin
      // the CSU rise is already the first command clock
      if (state_nxt != state)  cyc_cnt <= (state == S_CSU) ? 8'd1 : 8'd0;
      else if (rise_stb)       cyc_cnt <= cyc_cnt + 8'd1;

      if (accept) begin
        mode     <= t_rd_mode'(req_mode);
        out_sr   <= {rd_cmd(t_rd_mode'(req_mode)), req_addr};
        byte_cnt <= req_len;
        beat     <= '0;
        cs_n     <= 1'b0;
      end

      if (fall_stb && (state == S_CMD || state == S_ADDR))
        out_sr <= {out_sr[30:0], 1'b0};

      if (rise_stb && state == S_DATA) begin
        in_sr <= in_nxt;
        if (byte_done) begin
          beat <= '0;
          if (byte_cnt != '0) byte_cnt <= byte_cnt - 1'b1;
        end else begin
          beat <= beat + 3'd1;
        end
      end

      if (byte_done) begin
        rsp_valid <= 1'b1;
        rsp_data  <= in_nxt;
        rsp_last  <= (byte_cnt == '0);
      end else if (rsp_ready) begin
        rsp_valid <= 1'b0;
        rsp_last  <= 1'b0;
      end

      if (state == S_CSH && rise_stb) cs_n <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spi_flash_reader.sv
// tb_spi_flash_reader: directed bench pairing two reader instances (CLK_DIV 2 and 1) with a mem[i]=i flash model.
// Revision 1.0
`timescale 1ns/1ps
`default_nettype none
module tb_spi_flash_reader;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       sel = 1'b0;
  logic       rv0 = 1'b0, rv1 = 1'b0, rsp_ready = 1'b1;
  logic [1:0] req_mode = 2'd0;
  logic [23:0] req_addr = 24'd0;
  logic [7:0] req_len = 8'd0;
  logic [3:0] dq_i = 4'd0;

  logic       rr0, rsv0, rsl0, sck0, csn0, rr1, rsv1, rsl1, sck1, csn1;
  logic [7:0] rsd0, rsd1;
  logic [3:0] dqo0, dqt0, dqo1, dqt1;

  spi_flash_reader #(.CLK_DIV(2), .LEN_W(8), .DUMMY_CYC(0)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(rv0), .req_ready(rr0), .req_mode(req_mode),
    .req_addr(req_addr), .req_len(req_len), .rsp_valid(rsv0), .rsp_ready(rsp_ready),
    .rsp_data(rsd0), .rsp_last(rsl0), .sck(sck0), .cs_n(csn0), .dq_o(dqo0), .dq_t(dqt0), .dq_i(dq_i));

  spi_flash_reader #(.CLK_DIV(1), .LEN_W(8), .DUMMY_CYC(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(rv1), .req_ready(rr1), .req_mode(req_mode),
    .req_addr(req_addr), .req_len(req_len), .rsp_valid(rsv1), .rsp_ready(rsp_ready),
    .rsp_data(rsd1), .rsp_last(rsl1), .sck(sck1), .cs_n(csn1), .dq_o(dqo1), .dq_t(dqt1), .dq_i(dq_i));

  logic       sck_m, csn_m, rr_m, rsv_m, rsl_m;
  logic [7:0] rsd_m;
  logic [3:0] dqo_m, dqt_m;
  assign sck_m = sel ? sck1 : sck0;
  assign csn_m = sel ? csn1 : csn0;
  assign rr_m  = sel ? rr1  : rr0;
  assign rsv_m = sel ? rsv1 : rsv0;
  assign rsl_m = sel ? rsl1 : rsl0;
  assign rsd_m = sel ? rsd1 : rsd0;
  assign dqo_m = sel ? dqo1 : dqo0;
  assign dqt_m = sel ? dqt1 : dqt0;

  int n_chk = 0, n_fail = 0;

  // Flash model: 32 command/address bits in, data out on falling edges, mem[i] = i[7:0]
  int          m_rises = 0, m_chunk = 0, m_cpb = 8;
  logic [7:0]  m_cmd = 8'd0, m_byte, m_sh;
  logic [23:0] m_addr = 24'd0;
  logic        dqt_bad_cmd = 1'b0, dqt_bad_data = 1'b0;

  always @(negedge csn_m) begin
    m_rises = 0;
    m_chunk = 0;
  end

  always @(posedge sck_m) if (!csn_m) begin
    if (m_rises < 32 && dqt_m !== 4'b1110) dqt_bad_cmd = 1'b1;
    if (m_rises >= 32 && dqt_m !== 4'hF) dqt_bad_data = 1'b1;
    if (m_rises < 8)       m_cmd  = {m_cmd[6:0], dqo_m[0]};
    else if (m_rises < 32) m_addr = {m_addr[22:0], dqo_m[0]};
    m_rises++;
  end

  always @(negedge sck_m) if (!csn_m && m_rises >= 32) begin
    m_cpb  = (m_cmd == 8'h6B) ? 2 : ((m_cmd == 8'h3B) ? 4 : 8);
    m_byte = 8'(m_addr + 24'(m_chunk / m_cpb));
    m_sh   = m_byte << ((8 / m_cpb) * (m_chunk % m_cpb));
    case (m_cpb)
      2:       dq_i = m_sh[7:4];
      4:       dq_i = {2'b00, m_sh[7:6]};
      default: dq_i = {2'b00, m_sh[7], 1'b0};
    endcase
    m_chunk++;
  end

  // Monitors
  logic [7:0] q_data[$];
  logic       q_last[$];
  int         sck_edges = 0, hi_cnt = 0, last_gap = 0;
  logic       ready_bad = 1'b0;

  always @(posedge sck_m or negedge sck_m) sck_edges++;

  always @(negedge clk) begin
    if (rsv_m && rsp_ready) begin
      q_data.push_back(rsd_m);
      q_last.push_back(rsl_m);
    end
    if (!csn_m && rr_m) ready_bad = 1'b1;
    if (csn_m) hi_cnt++;
    else if (hi_cnt != 0) begin
      last_gap = hi_cnt;
      hi_cnt   = 0;
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (!rr_m && n < 4000) begin
      tick();
      n++;
    end
    check({tag, "_done"}, 32'(rr_m), 32'd1);
  endtask

  task automatic issue(input logic s, input logic [1:0] m, input logic [23:0] a, input logic [7:0] l);
    sel = s; req_mode = m; req_addr = a; req_len = l;
    ready_bad = 1'b0; dqt_bad_cmd = 1'b0; dqt_bad_data = 1'b0;
    if (s) rv1 = 1'b1; else rv0 = 1'b1;
    tick();
    rv0 = 1'b0;
    rv1 = 1'b0;
  endtask

  task automatic check_bytes(input string tag, input logic [7:0] first, input int n);
    check({tag, "_count"}, 32'(q_data.size()), 32'(n));
    for (int i = 0; i < n && i < q_data.size(); i++) begin
      check({tag, "_byte"}, 32'(q_data[i]), 32'(8'(first + 8'(i))));
      check({tag, "_last"}, 32'(q_last[i]), 32'(i == n - 1));
    end
    q_data.delete();
    q_last.delete();
  endtask

  initial begin
    int n;
    int e0;
    repeat (3) tick();
    check("rst_cs_n", 32'(csn0), 32'd1);
    check("rst_sck", 32'(sck0), 32'd0);
    check("rst_dq_o", 32'(dqo0), 32'h0);
    check("rst_dq_t", 32'(dqt0), 32'hF);
    check("rst_req_ready", 32'(rr0), 32'd1);
    check("rst_rsp_valid", 32'(rsv0), 32'd0);
    check("rst_rsp_last", 32'(rsl0), 32'd0);
    check("rst_cs_n_div1", 32'(csn1), 32'd1);
    rst_n = 1'b1;
    repeat (2) tick();

    // READ 0x000010 len 3
    issue(1'b0, 2'd0, 24'h000010, 8'd3);
    wait_idle("read");
    check("read_cmd", 32'(m_cmd), 32'h03);
    check("read_addr", 32'(m_addr), 32'h000010);
    check("read_sck_total", 32'(m_rises), 32'd64);
    check("read_dqt_cmd", 32'(dqt_bad_cmd), 32'd0);
    check("read_dqt_data", 32'(dqt_bad_data), 32'd0);
    check("read_ready_low", 32'(ready_bad), 32'd0);
    check_bytes("read", 8'h10, 4);

    // QUAD 0x000100 len 7
    issue(1'b0, 2'd3, 24'h000100, 8'd7);
    wait_idle("quad");
    check("quad_cmd", 32'(m_cmd), 32'h6B);
    check("quad_addr", 32'(m_addr), 32'h000100);
    check("quad_data_sck", 32'(m_rises - 32), 32'd16);
    check_bytes("quad", 8'h00, 8);

    // DUAL 0x0000FE len 1 on the CLK_DIV=1 instance
    issue(1'b1, 2'd2, 24'h0000FE, 8'd1);
    wait_idle("dual");
    check("dual_cmd", 32'(m_cmd), 32'h3B);
    check("dual_addr", 32'(m_addr), 32'h0000FE);
    check("dual_data_sck", 32'(m_rises - 32), 32'd8);
    check("dual_dqt_data", 32'(dqt_bad_data), 32'd0);
    check_bytes("dual", 8'hFE, 2);

    // FAST len 2 with the consumer stalled after the first byte
    rsp_ready = 1'b0;
    issue(1'b0, 2'd1, 24'h000000, 8'd2);
    n = 0;
    while (!rsv_m && n < 2000) begin
      tick();
      n++;
    end
    check("bp_first_valid", 32'(rsv_m), 32'd1);
    repeat (10) tick();
    e0 = sck_edges;
    repeat (40) tick();
    check("bp_no_edges", 32'(sck_edges - e0), 32'd0);
    check("bp_sck_low", 32'(sck_m), 32'd0);
    check("bp_cs_low", 32'(csn_m), 32'd0);
    rsp_ready = 1'b1;
    wait_idle("bp");
    check("bp_cmd", 32'(m_cmd), 32'h0B);
    check_bytes("bp", 8'h00, 3);

    // async reset in the middle of the address phase
    issue(1'b0, 2'd0, 24'h123456, 8'd3);
    n = 0;
    while (m_rises < 12 && n < 500) begin
      tick();
      n++;
    end
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_cs_n", 32'(csn0), 32'd1);
    check("mid_rst_sck", 32'(sck0), 32'd0);
    check("mid_rst_dq_t", 32'(dqt0), 32'hF);
    check("mid_rst_rsp_valid", 32'(rsv0), 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (2) tick();
    check("post_rst_no_bytes", 32'(q_data.size()), 32'd0);
    issue(1'b0, 2'd0, 24'h000005, 8'd0);
    wait_idle("post_rst");
    check_bytes("post_rst", 8'h05, 1);

    // back-to-back requests
    issue(1'b0, 2'd0, 24'h000020, 8'd0);
    wait_idle("b2b_a");
    check("b2b_a_ready_low", 32'(ready_bad), 32'd0);
    check_bytes("b2b_a", 8'h20, 1);
    issue(1'b0, 2'd0, 24'h000030, 8'd1);
    wait_idle("b2b_b");
    check("b2b_b_ready_low", 32'(ready_bad), 32'd0);
    check("b2b_gap_ge_half", 32'(last_gap >= 2), 32'd1);
    check_bytes("b2b_b", 8'h30, 2);

    repeat (4) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
